// File: rtl/uart_fifo_loop_ctrl.sv
// uart_fifo_loop_ctrl: sequences a UART/FIFO self-loop, filling FRAME_LEN received bytes then draining them to the transmitter.
module uart_fifo_loop_ctrl #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 9,
  parameter int ARM_TMO   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_din,
  output logic             fifo_rd_en,
  output logic             tx_en,
  output logic [7:0]       tx_din,
  input  logic             tx_busy,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             err_ovf,
  output logic             err_unf
);
  typedef enum logic [2:0] {IDLE, FILL, RD, LATCH, TX_GO, TX_ARM, TX_WAIT, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);
  localparam int TW = $clog2(ARM_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ARM_TMO - 1);
  state_t           state_q;
  logic [TW-1:0]    tmr_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic             wr_en_q, tx_en_q, done_q, ovf_q, unf_q;
  logic [7:0]       din_q, tx_din_q;
  logic             more_d;
  assign more_d     = rd_cnt_q < LAST;
  // Read strobe qualifies on the live empty flag so an underflow never pops.
  assign fifo_rd_en = (state_q == RD) && !fifo_empty;
  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign tx_en      = tx_en_q;
  assign tx_din     = tx_din_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = done_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;
  assign err_ovf    = ovf_q;
  assign err_unf    = unf_q;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_en_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      din_q    <= '0;
      tx_din_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      tx_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          wr_cnt_q <= '0;
          rd_cnt_q <= '0;
          ovf_q    <= 1'b0;
          unf_q    <= 1'b0;
          state_q  <= FILL;
        end
        // Leave FILL only once the last write is out so the strobes never overlap.
        FILL: if (wr_cnt_q == LAST) state_q <= RD;
          else if (rx_done && fifo_full) ovf_q <= 1'b1;
          else if (rx_done) begin
            wr_en_q  <= 1'b1;
            din_q    <= rx_data;
            wr_cnt_q <= wr_cnt_q + 1'b1;
          end
        RD: if (fifo_empty) begin
          unf_q   <= 1'b1;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else state_q <= LATCH;
        LATCH: begin
          tx_din_q <= fifo_dout;
          tx_en_q  <= 1'b1;
          state_q  <= TX_GO;
        end
        TX_GO: begin
          rd_cnt_q <= more_d ? rd_cnt_q + 1'b1 : rd_cnt_q;
          tmr_q    <= '0;
          state_q  <= TX_ARM;
        end
        TX_ARM: if (tx_busy) state_q <= TX_WAIT;
          else if (tmr_q == TMO_LAST) begin
            done_q  <= !more_d;
            state_q <= more_d ? RD : DONE;
          end else tmr_q <= tmr_q + 1'b1;
        TX_WAIT: if (!tx_busy) begin
          done_q  <= !more_d;
          state_q <= more_d ? RD : DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_fifo_loop_ctrl.md
# uart_fifo_loop_ctrl

Sequencer for the UART/FIFO self-loop datapath. The block runs in two phases. In the fill phase it writes FRAME_LEN bytes received by the UART receiver into the 8-bit FIFO. In the drain phase it reads them back and sends each one through the UART transmitter, one byte per transmitter busy cycle. It sits between uart_rx, the FIFO IP and uart_tx, and replaces ad-hoc enable logic at top level.

## Interface
Parameters:
- FRAME_LEN, 256, bytes per frame; legal range 1..(2^CNT_W − 1)
- CNT_W, 9, width of the byte counters
- ARM_TMO, 4, cycles to wait for tx_busy to rise after tx_en

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; starts a frame, only honoured in IDLE
- rx_done  in  1  one-cycle pulse; rx_data is valid
- rx_data  in  8  received byte
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd_en (standard mode)
- fifo_wr_en  out  1  FIFO write strobe
- fifo_din  out  8  FIFO write data
- fifo_rd_en  out  1  FIFO read strobe
- tx_en  out  1  one-cycle transmit request
- tx_din  out  8  transmit byte
- tx_busy  in  1  transmitter busy
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse when the frame completes or aborts
- wr_cnt  out  CNT_W  bytes written this frame
- rd_cnt  out  CNT_W  bytes transmitted this frame
- err_ovf  out  1  sticky: a byte was dropped because the FIFO was full
- err_unf  out  1  sticky: FIFO went empty before FRAME_LEN bytes were read

## Operation
- States: IDLE, FILL, RD, LATCH, TX_GO, TX_ARM, TX_WAIT, DONE.
- IDLE
  - start=1 clears wr_cnt, rd_cnt, err_ovf and err_unf, then goes to FILL.
  - rx_done in IDLE is ignored and nothing is written.
- FILL
  - On rx_done with fifo_full=0: next cycle fifo_wr_en=1 and fifo_din=rx_data; wr_cnt increments.
  - On rx_done with fifo_full=1: byte is dropped, err_ovf is set, wr_cnt is unchanged.
  - When wr_cnt reaches FRAME_LEN, go to RD. Any rx_done after that is ignored.
- RD
  - fifo_empty=1 sets err_unf and goes to DONE.
  - Otherwise fifo_rd_en=1 for exactly one cycle, then go to LATCH.
- LATCH: tx_din <= fifo_dout, go to TX_GO.
- TX_GO: tx_en=1 for one cycle; rd_cnt increments; go to TX_ARM.
- TX_ARM
  - Wait for tx_busy=1, then go to TX_WAIT.
  - If tx_busy stays low for ARM_TMO cycles, treat the byte as sent and continue as from TX_WAIT completion.
- TX_WAIT: on tx_busy=0, go to RD if rd_cnt<FRAME_LEN, else go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. wr_cnt, rd_cnt and the error flags hold until the next start.
- start outside IDLE is ignored.
- Counters saturate at FRAME_LEN and never wrap.
- sys_rst in any state, including mid-transmission:
  - next state is IDLE and all outputs take their reset values;
  - tx_en is never left asserted;
  - FIFO contents are not touched, because FIFO reset is owned by top level.

## Timing
- Reset values: every output is 0.
- rx_done at cycle N gives fifo_wr_en=1 at N+1, and wr_cnt updates at N+1.
- Drain sequence for one byte:
  - fifo_rd_en at cycle M;
  - tx_din valid at M+2;
  - tx_en high at M+2 only;
  - tx_din then holds stable until the next LATCH.
- Minimum cycles between two tx_en pulses: 4 plus the tx_busy high time.
- fifo_wr_en and fifo_rd_en are never high in the same cycle; the phases are exclusive.
- done rises exactly 1 cycle after the TX_WAIT exit (or after RD on underflow). busy falls in that same cycle.

## Test plan
- Reset with all inputs at 0, then pulse start: busy=1 next cycle, all other outputs 0. Pulse start again while busy: no effect.
- FRAME_LEN=4, feed rx bytes 0x11,0x22,0x33,0x44 spaced 10 cycles apart: four fifo_wr_en pulses with the matching fifo_din. Then four tx_en pulses carrying tx_din 0x11..0x44 in order, each one issued only after the previous tx_busy fall. Then done=1 with rd_cnt=4 and wr_cnt=4.
- During FILL hold fifo_full=1 for one rx_done: err_ovf=1, that byte is absent from the FIFO, and the frame still completes after 4 accepted bytes.
- Force fifo_empty=1 after 2 bytes drained: err_unf=1, done pulses, rd_cnt=2, FSM returns to IDLE.
- Transmitter model that never raises tx_busy: each byte advances after ARM_TMO=4 cycles and the frame completes.
- Assert sys_rst in TX_WAIT: next cycle every output is 0 and state is IDLE. A new start runs a clean frame.
